// File: rtl/snn_pkg.sv
// Shared types and default widths for the SNN event dispatcher slice.
package snn_pkg;

  localparam int N_PE_DEF        = 10;
  localparam int TIME_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 9;
  localparam int CNT_W_DEF       = 16;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4
  } disp_state_t;

  typedef logic [N_PE_DEF-1:0] done_mask_t;

endpackage

// File: rtl/snn_done_barrier.sv
// Accumulates per-PE done requests and reports when every PE has answered.
// DISPATCH_TIMEOUT_EN adds a watchdog that fires after TIMEOUT_CYC enabled cycles.
module snn_done_barrier
  import snn_pkg::*;
#(
  parameter int N_PE        = N_PE_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            local_clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [N_PE-1:0] done_req,
  output logic            all_done,
  output logic            timeout
);

  logic [N_PE-1:0] mask_r;
  logic [N_PE-1:0] merged_s;

  assign merged_s = mask_r | done_req;
  assign all_done = enable && (&merged_s);

  // done mask: cleared on issue, accumulates only while waiting
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      mask_r <= '0;
    end else if (clear) begin
      mask_r <= '0;
    end else if (enable) begin
      mask_r <= merged_s;
    end else begin
      mask_r <= mask_r;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_r;

  // timeout asserts on the TIMEOUT_CYC-th waiting cycle
  assign timeout = enable && !all_done && (wd_r == WD_W'(TIMEOUT_CYC - 1));

  // watchdog cycle counter for the current wait
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      wd_r <= '0;
    end else if (clear) begin
      wd_r <= '0;
    end else if (enable && !timeout) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/snn_event_dispatcher.sv
// Broadcasts AER events to all PEs and barriers on their done requests.
// Optional barrier watchdog: define DISPATCH_TIMEOUT_EN.
module snn_event_dispatcher
  import snn_pkg::*;
#(
  parameter int N_PE        = N_PE_DEF,
  parameter int TIME_W      = TIME_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              local_clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_evt_valid,
  output logic              o_evt_ready,
  input  logic [TIME_W-1:0] i_evt_time,
  input  logic [ADDR_W-1:0] i_evt_addr,
  input  logic              i_evt_last,
  output logic              o_aer_req,
  output logic [TIME_W-1:0] o_aer_time,
  output logic [ADDR_W-1:0] o_aer_addr,
  input  logic [N_PE-1:0]   i_done_req,
  output logic [N_PE-1:0]   o_done_ack,
  output logic              o_reset_potential,
  output logic              o_sample_done,
  output logic [CNT_W-1:0]  o_evt_count,
  output logic              o_busy,
  output logic              o_timeout_err
);

  disp_state_t       state_r, state_s;
  logic              start_pend_r;
  logic              last_r;
  logic [TIME_W-1:0] aer_time_r;
  logic [ADDR_W-1:0] aer_addr_r;
  logic [CNT_W-1:0]  count_r;
  logic              accept_s;
  logic              all_done_s;
  logic              timeout_s;

  snn_done_barrier #(
    .N_PE        (N_PE),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_barrier (
    .local_clk (local_clk),
    .rst       (rst),
    .clear     (state_r == ST_ISSUE),
    .enable    (state_r == ST_WAIT_DONE),
    .done_req  (i_done_req),
    .all_done  (all_done_s),
    .timeout   (timeout_s)
  );

  // ready is the only output with a path from an input (i_start)
  assign o_evt_ready       = (state_r == ST_IDLE) && !rst && !i_start && !start_pend_r;
  assign accept_s          = o_evt_ready && i_evt_valid;
  assign o_aer_req         = (state_r == ST_ISSUE);
  assign o_aer_time        = aer_time_r;
  assign o_aer_addr        = aer_addr_r;
  assign o_done_ack        = {N_PE{state_r == ST_ACK}};
  assign o_reset_potential = (state_r == ST_CLEAR);
  assign o_sample_done     = (state_r == ST_ACK) && last_r;
  assign o_evt_count       = count_r;
  assign o_busy            = (state_r != ST_IDLE);

  // state register
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start || start_pend_r) begin
          state_s = ST_CLEAR;
        end else if (accept_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR:     state_s = ST_IDLE;
      ST_ISSUE:     state_s = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (all_done_s || timeout_s) begin
          state_s = ST_ACK;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_ACK:       state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // event latch, pending start and saturating event counter
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      start_pend_r <= 1'b0;
      last_r       <= 1'b0;
      aer_time_r   <= '0;
      aer_addr_r   <= '0;
      count_r      <= '0;
    end else begin
      if (state_r == ST_CLEAR) begin
        start_pend_r <= 1'b0;
      end else if (i_start && (state_r != ST_IDLE)) begin
        start_pend_r <= 1'b1;
      end else begin
        start_pend_r <= start_pend_r;
      end
      if (accept_s) begin
        aer_time_r <= i_evt_time;
        aer_addr_r <= i_evt_addr;
        last_r     <= i_evt_last;
      end else begin
        aer_time_r <= aer_time_r;
        aer_addr_r <= aer_addr_r;
        last_r     <= last_r;
      end
      if (state_r == ST_CLEAR) begin
        count_r <= '0;
      end else if ((state_r == ST_ACK) && (count_r != {CNT_W{1'b1}})) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  logic err_r;

  assign o_timeout_err = err_r;

  // sticky watchdog flag, cleared only by a new sample
  always_ff @(posedge local_clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (state_r == ST_CLEAR) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_WAIT_DONE) && timeout_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_snn_event_dispatcher.sv
// Directed self-checking bench for snn_event_dispatcher (N_PE=4, CNT_W=2).
module tb_snn_event_dispatcher;

  localparam int N_PE   = 4;
  localparam int TIME_W = 32;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 2;

  logic              local_clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic              i_evt_valid;
  logic              o_evt_ready;
  logic [TIME_W-1:0] i_evt_time;
  logic [ADDR_W-1:0] i_evt_addr;
  logic              i_evt_last;
  logic              o_aer_req;
  logic [TIME_W-1:0] o_aer_time;
  logic [ADDR_W-1:0] o_aer_addr;
  logic [N_PE-1:0]   i_done_req;
  logic [N_PE-1:0]   o_done_ack;
  logic              o_reset_potential;
  logic              o_sample_done;
  logic [CNT_W-1:0]  o_evt_count;
  logic              o_busy;
  logic              o_timeout_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int nacc, nreq, req_cyc, ack_c;
  int acc_cyc [3];
  logic acc;

  snn_event_dispatcher #(
    .N_PE(N_PE), .TIME_W(TIME_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYC(64)
  ) dut (
    .local_clk(local_clk), .rst(rst), .i_start(i_start),
    .i_evt_valid(i_evt_valid), .o_evt_ready(o_evt_ready),
    .i_evt_time(i_evt_time), .i_evt_addr(i_evt_addr), .i_evt_last(i_evt_last),
    .o_aer_req(o_aer_req), .o_aer_time(o_aer_time), .o_aer_addr(o_aer_addr),
    .i_done_req(i_done_req), .o_done_ack(o_done_ack),
    .o_reset_potential(o_reset_potential), .o_sample_done(o_sample_done),
    .o_evt_count(o_evt_count), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  always #5 local_clk = ~local_clk;

  task automatic tick;
    @(posedge local_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one event from IDLE; PEs answer at t+5 and drop after the ack
  task automatic run_event(input logic [ADDR_W-1:0] addr, input logic [TIME_W-1:0] tim,
                           input logic last, input logic [CNT_W-1:0] exp_cnt);
    i_evt_valid = 1'b1; i_evt_addr = addr; i_evt_time = tim; i_evt_last = last;
    check("ev_ready", o_evt_ready, 1);
    tick;
    i_evt_valid = 1'b0;
    check("ev_req", o_aer_req, 1);
    check("ev_time", o_aer_time, tim);
    check("ev_addr", o_aer_addr, addr);
    check("ev_ready_busy", o_evt_ready, 0);
    tick;
    check("ev_req_once", o_aer_req, 0);
    tick; tick; tick;
    i_done_req = 4'hF;
    check("ev_no_early_ack", o_done_ack, 0);
    check("ev_addr_stable", o_aer_addr, addr);
    tick;
    check("ev_ack", o_done_ack, 4'hF);
    check("ev_sample_done", o_sample_done, last);
    i_done_req = 4'h0;
    tick;
    check("ev_ready_again", o_evt_ready, 1);
    check("ev_count", o_evt_count, exp_cnt);
    check("ev_ack_single", o_done_ack, 0);
    check("ev_sample_done_off", o_sample_done, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_evt_valid = 1'b0; i_evt_time = 32'd0;
    i_evt_addr = 9'd0; i_evt_last = 1'b0; i_done_req = 4'h0;
    tick; tick;
    check("rst_ready", o_evt_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_req", o_aer_req, 0);
    check("rst_count", o_evt_count, 0);
    check("rst_ack", o_done_ack, 0);
    check("rst_clear", o_reset_potential, 0);
    check("rst_time", o_aer_time, 0);
    check("rst_err", o_timeout_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", o_evt_ready, 1);

    // single event, last of sample
    run_event(9'd3, 32'd5, 1'b1, 2'd1);

    // done requests while idle are not acked
    i_done_req = 4'hF;
    tick; tick;
    check("idle_done_ignored", o_done_ack, 0);
    check("idle_not_busy", o_busy, 0);
    i_done_req = 4'h0;

    // staggered PE answers at 5,8,6,12 -> ack at 13
    i_evt_valid = 1'b1; i_evt_addr = 9'd7; i_evt_time = 32'hFFFF_FFFE; i_evt_last = 1'b0;
    tick;
    i_evt_valid = 1'b0;
    check("stag_time", o_aer_time, 32'hFFFF_FFFE);
    for (int c = 2; c <= 14; c++) begin
      tick;
      if (c >= 14) i_done_req = 4'h0;
      else i_done_req = {(c >= 12), (c >= 6), (c >= 8), (c >= 5)};
      check("stag_ack", o_done_ack, (c == 13) ? 4'hF : 4'h0);
      check("stag_sample_done", o_sample_done, 0);
    end
    check("stag_count", o_evt_count, 2);
    check("stag_ready", o_evt_ready, 1);

    // start during WAIT_DONE: event completes, then CLEAR
    i_evt_valid = 1'b1; i_evt_addr = 9'd20; i_evt_last = 1'b0;
    tick;
    i_evt_valid = 1'b0;
    tick;
    i_start = 1'b1;
    check("pend_ready", o_evt_ready, 0);
    tick;
    i_start = 1'b0;
    tick; tick;
    i_done_req = 4'hF;
    tick;
    check("pend_ack", o_done_ack, 4'hF);
    check("pend_no_clear_yet", o_reset_potential, 0);
    i_done_req = 4'h0;
    tick;
    check("pend_idle", o_busy, 0);
    check("pend_ready_low", o_evt_ready, 0);
    check("pend_count_inc", o_evt_count, 3);
    tick;
    check("pend_clear", o_reset_potential, 1);
    check("pend_clear_ready", o_evt_ready, 0);
    tick;
    check("pend_clear_once", o_reset_potential, 0);
    check("pend_count_zero", o_evt_count, 0);
    check("pend_ready_back", o_evt_ready, 1);

    // start in IDLE drops ready combinationally
    i_start = 1'b1;
    #1;
    check("start_ready_low", o_evt_ready, 0);
    tick;
    i_start = 1'b0;
    check("idle_start_clear", o_reset_potential, 1);
    tick;
    check("idle_start_back", o_evt_ready, 1);

    // back-to-back: valid held high for three events
    nacc = 0; nreq = 0; req_cyc = -100;
    i_evt_valid = 1'b1; i_evt_addr = 9'd10; i_evt_time = 32'd100; i_evt_last = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      acc = o_evt_ready && i_evt_valid;
      tick;
      if (acc) begin
        acc_cyc[nacc] = c;
        nacc++;
        if (nacc < 3) begin
          i_evt_addr = ADDR_W'(10 + nacc);
          i_evt_last = (nacc == 2);
        end else begin
          i_evt_valid = 1'b0;
        end
      end
      if (o_aer_req) begin
        check("b2b_addr", o_aer_addr, 10 + nreq);
        req_cyc = c;
        nreq++;
      end
      if (o_done_ack != 4'h0) i_done_req = 4'h0;
      else if (c == req_cyc + 4) i_done_req = 4'hF;
      check("b2b_sample_done", o_sample_done, (c == 20));
    end
    check("b2b_nacc", nacc, 3);
    check("b2b_nreq", nreq, 3);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 7);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 7);
    check("b2b_count", o_evt_count, 3);

    // saturation: events 4 and 5 keep count at 3
    run_event(9'd30, 32'd7, 1'b0, 2'd3);
    run_event(9'd31, 32'd8, 1'b1, 2'd3);

    // PE 3 never answers
    i_evt_valid = 1'b1; i_evt_addr = 9'd40; i_evt_last = 1'b0;
    tick;
    i_evt_valid = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    ack_c = -1;
    for (int c = 2; c <= 90; c++) begin
      tick;
      i_done_req = (c >= 5) ? 4'b0111 : 4'b0000;
      if ((o_done_ack != 4'h0) && (ack_c < 0)) ack_c = c;
    end
    check("to_ack_cycle", ack_c, 66);
    check("to_err_sticky", o_timeout_err, 1);
    check("to_count_sat", o_evt_count, 3);
    i_done_req = 4'h0;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick;
    check("to_err_cleared", o_timeout_err, 0);
`else
    for (int c = 2; c <= 100; c++) begin
      tick;
      i_done_req = (c >= 5) ? 4'b0111 : 4'b0000;
    end
    check("nto_busy", o_busy, 1);
    check("nto_no_ack", o_done_ack, 0);
    check("nto_err", o_timeout_err, 0);
    i_done_req = 4'hF;
    tick;
    check("nto_ack", o_done_ack, 4'hF);
    i_done_req = 4'h0;
    tick;
    check("nto_ready", o_evt_ready, 1);
`endif

    // reset in the middle of a wait
    i_evt_valid = 1'b1; i_evt_addr = 9'd50; i_evt_last = 1'b0;
    tick;
    i_evt_valid = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_evt_ready, 0);
    check("mid_rst_ack", o_done_ack, 0);
    check("mid_rst_addr", o_aer_addr, 0);
    tick;
    rst = 1'b0;
    #1;
    check("mid_rst_ready_back", o_evt_ready, 1);
    check("mid_rst_count", o_evt_count, 0);
    check("mid_rst_err", o_timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_event_dispatcher.md
# snn_event_dispatcher

Sits between the AER encoder and the array of N_PE processing elements. Accepts one AER event at a time from the encoder over valid/ready, broadcasts it to all PEs as a single-cycle request with stable time/address, and barriers on every PE's done request. Only then does it acknowledge the PEs and accept the next event. Also generates the per-sample potential reset, counts events and flags sample completion for the ArgMax stage.

## Interface
- N_PE, 10: number of PEs on the broadcast bus
- TIME_W, 32: signed spike-time width
- ADDR_W, 9: source-neuron (weight BRAM) address width
- CNT_W, 16: event counter width
- TIMEOUT_CYC, 64: barrier watchdog limit (used only with timeout feature)
- local_clk  in  1  the single clock; one clock domain only
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  pulse: begin new sample
- i_evt_valid  in  1  encoder event valid
- o_evt_ready  out  1  dispatcher can accept event
- i_evt_time  in  TIME_W  signed spike time
- i_evt_addr  in  ADDR_W  source address
- i_evt_last  in  1  event is last of sample
- o_aer_req  out  1  one-cycle broadcast request to all PEs
- o_aer_time  out  TIME_W  held time for PEs
- o_aer_addr  out  ADDR_W  held address for PEs
- i_done_req  in  N_PE  per-PE done request (level, held until ack)
- o_done_ack  out  N_PE  per-PE ack, one-cycle pulse
- o_reset_potential  out  1  one-cycle clear of all PE potentials
- o_sample_done  out  1  one-cycle pulse after last event retired
- o_evt_count  out  CNT_W  events retired this sample, saturating
- o_busy  out  1  state != IDLE
- o_timeout_err  out  1  sticky barrier-timeout flag

## Operation
- States: IDLE, CLEAR, ISSUE, WAIT_DONE, ACK.
- IDLE: o_evt_ready = (state==IDLE) && !i_start && !start_pend. Start (i_start or start_pend) -> CLEAR. Else valid&&ready -> latch time/addr/last into o_aer_time/o_aer_addr/last_q -> ISSUE.
- CLEAR: o_reset_potential=1, o_evt_count=0, start_pend=0, o_timeout_err=0 -> IDLE.
- ISSUE: o_aer_req=1, done_mask=0 -> WAIT_DONE.
- WAIT_DONE: done_mask <= done_mask | i_done_req. When (done_mask | i_done_req) is all ones -> ACK.
- ACK: o_done_ack = all ones; o_evt_count += 1 (saturates at 2^CNT_W-1); if last_q then o_sample_done=1 -> IDLE.
- i_start outside IDLE/CLEAR: sets start_pend; the current event completes normally, then CLEAR.
- o_aer_time/o_aer_addr are stable from ISSUE until the next acceptance; PEs latch them one cycle after seeing o_aer_req.
- Extra i_done_req bits already in mask are harmless; a PE req seen in IDLE/ISSUE is ignored (not acked).

## Timing
- All outputs zero in reset; o_evt_ready 0 while rst high, then 1 (IDLE).
- Outputs decode from registered state/regs; no input-to-output combinational path except o_evt_ready on i_start.
- Accept edge at cycle t: ISSUE t+1, PE done req earliest t+5, ACK t+6, ready again t+7. Minimum 7 cycles per event.
- ACK is always ≥1 cycle after the last done bit was first seen, so the ack lands while each PE is in its wait-ack state.
- o_sample_done coincides with the ACK cycle of the last event; o_evt_count reflects the increment the following cycle.
- rst mid-operation: immediate return to IDLE, mask/count/pend/err cleared, no ack issued.

## Configuration
- DISPATCH_TIMEOUT_EN defined: a cycle counter runs in WAIT_DONE. On reaching TIMEOUT_CYC without a full mask, it sets o_timeout_err (sticky until CLEAR) and forces ACK; all-ones ack, count increments.
- Undefined: no counter, o_timeout_err tied 0, WAIT_DONE waits indefinitely.

## Structure
- Shared package snn_pkg: state enum, TIME_W/ADDR_W/CNT_W defaults, done-mask type.
- One sub-module, snn_done_barrier: mask accumulate, all-done detect, optional watchdog. Inputs are clear/enable; outputs are all_done and timeout.

## Test plan
- Reset then single event time=5, addr=3, last=1, PEs answer at t+5 -> one o_aer_req, ack all at t+6, o_sample_done pulse, count=1.
- N_PE=4, PEs raise done at staggered cycles 5,8,6,12 -> ACK exactly one cycle after the bit-3 arrival, single ack pulse to all.
- i_start during WAIT_DONE -> event finishes, then CLEAR: o_reset_potential one cycle, count 0, ready low until back in IDLE.
- Valid held high with 3 back-to-back events -> accepted every 7 cycles minimum, addresses appear in order, count=3.
- DISPATCH_TIMEOUT_EN, TIMEOUT_CYC=64, one PE never responds -> o_timeout_err high at cycle 64 of WAIT_DONE, forced ack, cleared by next i_start.
- Count saturation with CNT_W=2, 5 events -> count holds at 3.
